// File: rtl/shift_reg_pkg.sv
// Constants shared by the shift-register link transmitter and receiver.
// The word width is always a power of two, derived from DATA_WIDTH.
package shift_reg_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 4;
  localparam int DEFAULT_SYNC_STAGES = 2;

  function automatic int word_width(input int data_width);
    return 1 << data_width;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for one asynchronous pin, with a rising-edge flag
// derived from the synchronized level and its one-cycle-delayed copy.
module sync_edge_detect
  import shift_reg_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchronizer chain plus the previous synced level for edge detection
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_pin};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign o_level = sync_q[SYNC_STAGES-1];
  assign o_rise  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/shift_reg_receiver.sv
// Serial-to-parallel receiver for the data/shift-clock/latch link: shifts on
// each synced shift-clock rise, presents the word and a frame check on latch.
module shift_reg_receiver
  import shift_reg_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                               i_clk,
  input  logic                               i_reset_n,
  input  logic                               i_ds,
  input  logic                               i_sh_clk,
  input  logic                               i_sh_latch,
  output logic [word_width(DATA_WIDTH)-1:0]  o_data,
  output logic                               o_valid,
  output logic                               o_frame_err,
  output logic [DATA_WIDTH:0]                o_bit_count
);

  localparam int W          = word_width(DATA_WIDTH);
  localparam int CNT_W      = DATA_WIDTH + 1;
  localparam int ARM_CYCLES = SYNC_STAGES + 1;
  localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

  logic ds_level_s, sh_level_s, sh_rise_raw_s, latch_level_s, latch_rise_raw_s;
  logic armed_s, sh_rise_s, latch_rise_s;

  logic [ARM_W-1:0] arm_q, arm_d;
  logic [W-1:0]     shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ds (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_pin(i_ds),
    .o_level(ds_level_s), .o_rise()
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sh_clk (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_pin(i_sh_clk),
    .o_level(sh_level_s), .o_rise(sh_rise_raw_s)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_pin(i_sh_latch),
    .o_level(latch_level_s), .o_rise(latch_rise_raw_s)
  );

  // Edges are ignored until the synchronizers have filled with real pin values
  assign armed_s      = (arm_q == ARM_W'(ARM_CYCLES));
  assign sh_rise_s    = sh_rise_raw_s & armed_s;
  assign latch_rise_s = latch_rise_raw_s & armed_s;

  // Next-state: shift is applied before latch so a coincident latch sees the new bit
  always_comb begin
    arm_d   = arm_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    if (!armed_s) begin
      arm_d = arm_q + ARM_W'(1);
    end else begin
      arm_d = arm_q;
    end

    if (sh_rise_s) begin
      shift_d = {shift_q[W-2:0], ds_level_s};
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      shift_d = shift_q;
    end

    if (latch_rise_s) begin
      data_d  = shift_d;
      valid_d = 1'b1;
      ferr_d  = (cnt_d != CNT_W'(W));
      cnt_d   = '0;
    end else begin
      data_d  = data_q;
    end
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      arm_q   <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      arm_q   <= arm_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_bit_count = cnt_q;

  // Synced levels are only consumed through their edge flags
  logic unused_levels_s;
  assign unused_levels_s = sh_level_s ^ latch_level_s;

endmodule

// File: tb/tb_shift_reg_receiver.sv
// Randomized bench for shift_reg_receiver: drives the link pins at cycle level
// and compares against a word/bit-count model of the link protocol.
module tb_shift_reg_receiver;

  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ds = 1'b0, sh_clk = 1'b0, sh_latch = 1'b0;
  logic [15:0] o_data;
  logic        o_valid, o_frame_err;
  logic [4:0]  o_bit_count;

  int errors = 0;
  int checks = 0;
  int valid_pulses = 0;
  int latches_sent = 0;

  // Model state: last W bits seen on the link and bits since the last latch
  logic [15:0] mdl_word = 16'h0000;
  int          mdl_cnt = 0;

  shift_reg_receiver #(.DATA_WIDTH(4), .SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_ds(ds), .i_sh_clk(sh_clk),
    .i_sh_latch(sh_latch), .o_data(o_data), .o_valid(o_valid),
    .o_frame_err(o_frame_err), .o_bit_count(o_bit_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_valid === 1'b1) valid_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_shift(input logic b);
    mdl_word = {mdl_word[14:0], b};
    mdl_cnt  = (mdl_cnt < 31) ? mdl_cnt + 1 : 31;
  endtask

  task automatic send_bit(input logic b);
    ds = b;
    repeat (4) tick();
    sh_clk = 1'b1;
    model_shift(b);
    repeat (4) tick();
    check("bit_count", 32'(o_bit_count), 32'(mdl_cnt));
    sh_clk = 1'b0;
    repeat (4) tick();
  endtask

  // Raise latch (optionally together with one last shift) and check the valid window
  task automatic latch_frame(input string tag, input logic simul, input logic b);
    logic [15:0] exp_data;
    logic        exp_err;
    if (simul) begin
      ds = b;
      repeat (4) tick();
      sh_clk = 1'b1;
      model_shift(b);
    end
    sh_latch = 1'b1;
    latches_sent++;
    exp_data = mdl_word;
    exp_err  = (mdl_cnt != W);
    mdl_cnt  = 0;
    tick();
    check({tag, "_early_valid1"}, 32'(o_valid), 32'd0);
    tick();
    check({tag, "_early_valid2"}, 32'(o_valid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(o_valid), 32'd1);
    check({tag, "_data"}, 32'(o_data), 32'(exp_data));
    check({tag, "_frame_err"}, 32'(o_frame_err), 32'(exp_err));
    tick();
    check({tag, "_valid_drop"}, 32'(o_valid), 32'd0);
    check({tag, "_cnt_clear"}, 32'(o_bit_count), 32'd0);
    tick();
    sh_latch = 1'b0;
    sh_clk   = 1'b0;
    repeat (4) tick();
  endtask

  task automatic send_word(input logic [15:0] w, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  initial begin
    logic [15:0] rnd;
    int          len;

    // Reset held while pins toggle
    for (int i = 0; i < 8; i++) begin
      ds = 1'($urandom); sh_clk = 1'($urandom); sh_latch = 1'($urandom);
      tick();
    end
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_ferr", 32'(o_frame_err), 32'd0);
    check("rst_cnt", 32'(o_bit_count), 32'd0);

    // Release with clock and latch pins already high: no spurious edge
    sh_clk = 1'b1; sh_latch = 1'b1; ds = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    check("arm_no_valid", 32'(valid_pulses), 32'd0);
    check("arm_cnt", 32'(o_bit_count), 32'd0);
    sh_clk = 1'b0; sh_latch = 1'b0;
    repeat (6) tick();

    send_word(16'hA5C3, 16);
    latch_frame("nominal", 1'b0, 1'b0);

    send_word(16'h0FFF, 12);
    latch_frame("short", 1'b0, 1'b0);
    check("short_word", 32'(o_data), 32'h3FFF);

    send_word(16'h1234 >> 1, 15);
    latch_frame("simul", 1'b1, 1'b0);
    check("simul_word", 32'(o_data), 32'h1234);

    // Mid-frame reset discards the partial frame and the held word
    send_word(16'h007F, 7);
    rst_n = 1'b0;
    repeat (3) tick();
    check("midrst_cnt", 32'(o_bit_count), 32'd0);
    check("midrst_data", 32'(o_data), 32'd0);
    rst_n = 1'b1;
    mdl_word = 16'h0000;
    mdl_cnt  = 0;
    repeat (6) tick();
    send_word(16'h0F0F, 16);
    latch_frame("midrst", 1'b0, 1'b0);

    send_word(16'h3F06, 16);
    latch_frame("pattern", 1'b0, 1'b0);

    // Long frame drives the bit counter into saturation
    for (int i = 0; i < 35; i++) send_bit(1'($urandom));
    check("sat_cnt", 32'(o_bit_count), 32'd31);
    latch_frame("long", 1'b0, 1'b0);

    // Random frame lengths around W, some ending on a coincident latch
    for (int f = 0; f < 8; f++) begin
      rnd = 16'($urandom);
      len = $urandom_range(13, 19);
      if ($urandom_range(0, 1) == 1) begin
        send_word(rnd >> 1, len - 1);
        latch_frame("rand_simul", 1'b1, rnd[0]);
      end else begin
        send_word(rnd, len);
        latch_frame("rand", 1'b0, 1'b0);
      end
    end

    repeat (4) tick();
    check("valid_pulse_total", 32'(valid_pulses), 32'(latches_sent));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_reg_receiver.md
# shift_reg_receiver

Serial-to-parallel receiver for the three-wire shift-register link (data, shift clock, latch) that `shift_reg_output` drives. It oversamples the asynchronous link pins on the system clock and shifts data in on each rising shift clock. On each rising latch it presents the completed word with a one-cycle valid pulse and a frame-length check. It sits on input pins for board-to-board links and serves as the loopback checker for the seven-segment driver chain.

## Interface
- `DATA_WIDTH`, default 4: log2 of the word width, same meaning as in `shift_reg_output`. W = 2^DATA_WIDTH = 16 bits by default.
- `SYNC_STAGES`, default 2: synchronizer flops per input pin; minimum 2.
- `i_clk`  in  1: system clock (16 MHz on board).
- `i_reset_n`  in  1: asynchronous, active-low reset.
- `i_ds`  in  1: serial data pin; asynchronous to `i_clk`.
- `i_sh_clk`  in  1: shift clock pin; asynchronous.
- `i_sh_latch`  in  1: latch pin; asynchronous.
- `o_data`  out  W: last latched word.
- `o_valid`  out  1: one-cycle pulse when `o_data` updates.
- `o_frame_err`  out  1: one-cycle pulse, coincident with `o_valid`, when the frame bit count ≠ W.
- `o_bit_count`  out  DATA_WIDTH+1: bits shifted since the last latch; saturates at all-ones.

## Operation
- All three pins pass through `SYNC_STAGES`-deep synchronizers of equal depth, so `ds`, `sh_clk` and `latch` remain mutually aligned.
- A rise on `sh_clk` or `latch` is detected when its synced value is 1 and the previous synced value was 0.
- **Shift (`sh_clk` rise):**
  - shift_reg <= {shift_reg[W-2:0], ds_sync}, so the first bit received ends up at the MSB (MSB-first link).
  - Bit count increments, saturating at 2^(DATA_WIDTH+1)-1.
- **Latch (`latch` rise):**
  - o_data <= shift_reg.
  - `o_valid` pulses for one cycle.
  - `o_frame_err` = (bit count ≠ W).
  - Bit count clears to 0.
  - shift_reg is NOT cleared; it keeps its contents, as a 595 does.
- **Simultaneous `sh_clk` rise and `latch` rise in the same cycle:** the shift is applied first. `o_data` captures the post-shift value, and the frame check counts the new bit.
- **More than W bits before a latch:** `o_data` holds the last W bits received and `o_frame_err` is 1.
- **Arming:** after reset deassertion, edge detection is suppressed for `SYNC_STAGES`+1 cycles. A pin already high at reset release therefore produces no spurious edge.
- **Reset (asynchronous, any time including mid-frame):**
  - Clears synchronizers, shift_reg, bit count, `o_data`, `o_valid`, `o_frame_err` and the arming counter, all to 0.
  - The partial frame is discarded.

## Timing
- Input requirements, in `i_clk` cycles:
  - `sh_clk` high ≥ `SYNC_STAGES`+1 and low ≥ `SYNC_STAGES`+1.
  - `latch` high ≥ `SYNC_STAGES`+1 and low ≥ `SYNC_STAGES`+1.
  - `ds` stable from 2 cycles before to `SYNC_STAGES` cycles after each `sh_clk` rise.
  - Faster toggling is out of specification; there is no detection requirement.
- Latency: `o_valid` asserts `SYNC_STAGES`+1 `i_clk` rising edges after the first edge that samples `i_sh_latch` high. This is 3 cycles with the defaults.
- `o_data`, `o_frame_err` and `o_bit_count` are registered. `o_data` changes only in the `o_valid` cycle.
- There is no backpressure. Every latch produces exactly one `o_valid` pulse.

## Structure
- Shared package `shift_reg_pkg` holds the constants common to `shift_reg_output` and this block:
  - `DEFAULT_DATA_WIDTH` = 4
  - `DEFAULT_SYNC_STAGES` = 2
  - word-width function W = 1 << DATA_WIDTH
- Sub-module `sync_edge_detect`: parameter `SYNC_STAGES`; outputs `o_level` and `o_rise`. It is instantiated three times; `ds` uses `o_level` only.
- The top of the block contains the arming counter, shift register, bit counter and output registers.

## Test plan
- **Reset:** hold `i_reset_n`=0 while toggling all pins → all outputs 0. Release with `i_sh_clk`=1 and `i_sh_latch`=1 → no `o_valid` and `o_bit_count`=0.
- **Nominal frame:** send 0xA5C3 MSB-first with a shift-clock half period of 4 cycles, then latch → `o_data`=0xA5C3, a single `o_valid` pulse exactly 3 cycles after the latch rise, `o_frame_err`=0, `o_bit_count` returns to 0.
- **Short frame:** after 0xA5C3, send 12 bits 0xFFF and latch → `o_data`=0x3FFF, `o_frame_err`=1 together with `o_valid`.
- **Simultaneous edge:** the 16th `sh_clk` rise and the `latch` rise occur on the same cycle for 0x1234 → `o_data`=0x1234, no frame error.
- **Mid-frame reset:** pulse `i_reset_n` low after 7 bits, then send a full 0x0F0F frame → `o_data`=0x0F0F, no frame error.
- **Loopback:** `shift_reg_output` (DATA_WIDTH=4) drives the pins with 0x3F06 → `o_data`=0x3F06 with one `o_valid` per transmitter latch.
